// File: rtl/frame_packer_multi.sv
// frame_packer_multi: header-locked frame packer.
// Packs DIN_WIDTH input words into tagged 36-bit FIFO words.
module frame_packer_multi #(
   parameter int         DIN_WIDTH    = 8,
   parameter int         FIFO_WIDTH   = 36,
   parameter int         FRAME_WIDTH  = 48,
   parameter logic [7:0] FRAME_HEADER = 8'hBC,
   parameter int         NFRAMES_AUTO = 100,
   parameter int         NFRAMES_TRIG = 1,
   parameter int         MISS_MAX     = 2,
   parameter int         CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  trigger,
   input  logic                  stop,
   input  logic [DIN_WIDTH-1:0]  din,
   input  logic                  evt_trig,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  locked,
   output logic                  busy,
   output logic [7:0]            drop_cnt
);

   localparam int PACK   = 32 / DIN_WIDTH;
   localparam int NWORDS = FRAME_WIDTH / PACK;
   localparam bit B2B_OK = (NWORDS + 2) <= FRAME_WIDTH;
   localparam int PW     = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam int MW     = $clog2(MISS_MAX + 1);

   typedef enum logic [1:0] {SEEK, LOCKED, CAPTURE, TRAILER} state_t;

   state_t               state, state_nx;
   logic [PW-1:0]        pos, pos_nx, pos_inc;
   logic [MW-1:0]        miss_cnt, miss_nx, miss_inc, miss_chk;
   logic [CNT_WIDTH-1:0] frames_left, fl_dec, seq;
   logic [31:0]          evt_cnt, evt_snap, pack, shifted;
   logic                 evt_q, evt_pend, ovf;
   logic                 hdr, slot, pos_last, word_due, lose, fl_live;
   logic                 go_cap, b2b, drop_now, abort;
   logic                 wr_evt, wr_data, wr_trl, wr_nx;
   logic [7:0]           drop_inc;
   logic [FIFO_WIDTH-1:0] dout_nx;

   assign hdr      = din[7:0] == FRAME_HEADER;
   assign slot     = pos == '0;
   assign pos_last = pos == PW'(FRAME_WIDTH - 1);
   assign pos_inc  = pos_last ? '0 : pos + 1'b1;
   assign word_due = (int'(pos) % PACK) == (PACK - 1);
   assign shifted  = (pack << DIN_WIDTH) | 32'(din);
   assign miss_inc = (miss_cnt == MW'(MISS_MAX)) ? miss_cnt
                                                 : miss_cnt + 1'b1;
   assign miss_chk = slot ? (hdr ? '0 : miss_inc) : miss_cnt;
   assign lose     = miss_chk >= MW'(MISS_MAX);
   assign fl_live  = frames_left != '0;
   assign fl_dec   = fl_live ? frames_left - 1'b1 : '0;
   assign drop_inc = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 1'b1;

   assign locked = state != SEEK;
   assign busy   = fl_live || state == CAPTURE || state == TRAILER;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SEEK;
         pos         <= '0;
         miss_cnt    <= '0;
         frames_left <= '0;
         seq         <= '0;
         drop_cnt    <= '0;
         evt_q       <= 1'b0;
         evt_cnt     <= '0;
         evt_snap    <= '0;
         evt_pend    <= 1'b0;
         pack        <= '0;
         ovf         <= 1'b0;
         fifo_wr_en  <= 1'b0;
         data_out    <= '0;
      end else begin
         state      <= state_nx;
         pos        <= pos_nx;
         miss_cnt   <= miss_nx;
         fifo_wr_en <= wr_nx;
         data_out   <= dout_nx;
         evt_q      <= evt_trig;
         if (evt_trig && !evt_q)
            evt_cnt <= evt_cnt + 32'd1;
         if (go_cap)
            pack <= 32'(din);
         else if (state == CAPTURE)
            pack <= shifted;
         if (b2b) begin
            evt_pend <= 1'b1;
            evt_snap <= evt_cnt;
         end else if (wr_evt || state_nx == TRAILER) begin
            evt_pend <= 1'b0;
         end
         if (abort)
            ovf <= 1'b1;
         else if (wr_trl)
            ovf <= 1'b0;
         if (start)
            frames_left <= CNT_WIDTH'(NFRAMES_AUTO);
         else if (trigger)
            frames_left <= CNT_WIDTH'(NFRAMES_TRIG);
         else if (stop)
            frames_left <= '0;
         else if (wr_trl)
            frames_left <= fl_dec;
         if (start || trigger)
            seq <= '0;
         else if (wr_trl)
            seq <= seq + 1'b1;
         if (start || trigger)
            drop_cnt <= '0;
         else if (drop_now)
            drop_cnt <= drop_inc;
      end
   end

   // Next state, lock tracking and write decisions
   always_comb begin
      state_nx = state;
      pos_nx   = pos_inc;
      miss_nx  = miss_chk;
      go_cap   = 1'b0;
      b2b      = 1'b0;
      drop_now = 1'b0;
      abort    = 1'b0;
      wr_evt   = 1'b0;
      wr_data  = 1'b0;
      wr_trl   = 1'b0;
      unique case (state)
         SEEK: begin
            pos_nx  = '0;
            miss_nx = '0;
            if (hdr) begin
               pos_nx   = PW'(1);
               state_nx = LOCKED;
            end
         end
         LOCKED: begin
            if (slot && hdr && fl_live) begin
               if (fifo_full) begin
                  drop_now = 1'b1;
               end else begin
                  go_cap   = 1'b1;
                  wr_evt   = 1'b1;
                  state_nx = CAPTURE;
               end
            end else if (lose) begin
               state_nx = SEEK;
            end
         end
         CAPTURE: begin
            if (evt_pend || word_due) begin
               if (fifo_full) begin
                  abort    = 1'b1;
                  state_nx = TRAILER;
               end else if (word_due) begin
                  wr_data = 1'b1;
                  if (pos_last)
                     state_nx = TRAILER;
               end else begin
                  wr_evt = 1'b1;
               end
            end
         end
         TRAILER: begin
            if (!fifo_full) begin
               wr_trl   = 1'b1;
               state_nx = lose ? SEEK : LOCKED;
               if (slot && hdr && fl_dec != '0) begin
                  if (B2B_OK) begin
                     go_cap   = 1'b1;
                     b2b      = 1'b1;
                     state_nx = CAPTURE;
                  end else begin
                     drop_now = 1'b1;
                  end
               end
            end else if (slot && fl_live) begin
               drop_now = 1'b1;
            end
         end
         default: state_nx = SEEK;
      endcase
   end

   // Tagged output word selection
   always_comb begin
      wr_nx   = 1'b0;
      dout_nx = data_out;
      unique case (1'b1)
         wr_evt: begin
            wr_nx   = 1'b1;
            dout_nx = {4'h1, evt_pend ? evt_snap : evt_cnt};
         end
         wr_data: begin
            wr_nx   = 1'b1;
            dout_nx = {4'h0, shifted};
         end
         wr_trl: begin
            wr_nx   = 1'b1;
            dout_nx = {4'h2, 16'(seq), drop_cnt, 7'b0, ovf};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_frame_packer_multi.sv
// tb_frame_packer_multi: randomized scenarios vs a
// frame-level expected word stream.
module tb_frame_packer_multi;

   localparam int FW   = 48;
   localparam int PACK = 4;
   localparam int NONE = -1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        trigger = 1'b0;
   logic        stop = 1'b0;
   logic        evt_trig = 1'b0;
   logic        fifo_full = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        fifo_wr_en;
   logic [35:0] data_out;
   logic        locked;
   logic        busy;
   logic [7:0]  drop_cnt;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [35:0] got_q[$];
   logic [35:0] exp_q[$];
   logic [7:0]  slot_b[FW];
   logic [31:0] evt_total = 0;
   logic [31:0] slot_evt = 0;

   frame_packer_multi #(.NFRAMES_AUTO(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .trigger(trigger), .stop(stop), .din(din),
      .evt_trig(evt_trig), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .data_out(data_out),
      .locked(locked), .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (fifo_wr_en) got_q.push_back(data_out);

   function automatic logic [7:0] rnd_byte();
      logic [7:0] r;
      r = 8'($urandom);
      if (r == 8'hBC) r = 8'h3C;
      return r;
   endfunction

   task automatic drive(input logic [7:0] b, input bit f,
                        input int cmd, input bit e);
      @(posedge clk);
      #1;
      din = b;
      fifo_full = f;
      start = (cmd == 1);
      trigger = (cmd == 2);
      stop = (cmd == 3);
      evt_trig = e;
   endtask

   // one header slot; cmd 1=start 2=trigger 3=stop
   task automatic send_slot(input bit hdr, input int len,
                            input int cmd, input int cmd_at,
                            input int ff, input int fl,
                            input int n_evt);
      logic [7:0] b;
      bit e;
      slot_evt = evt_total;
      for (int w = 0; w < len; w++) begin
         b = (w == 0 && hdr) ? 8'hBC : rnd_byte();
         slot_b[w] = b;
         e = (w >= 10) && (w < 10 + 2 * n_evt) && (w % 2 == 0);
         if (e) evt_total = evt_total + 1;
         drive(b, (w >= ff) && (w < ff + fl),
               (w == cmd_at) ? cmd : 0, e);
      end
   endtask

   task automatic exp_frame(input int nd, input bit trl,
                            input bit ovf, input int sq,
                            input int dr);
      exp_q.push_back({4'h1, slot_evt});
      for (int k = 0; k < nd; k++)
         exp_q.push_back({4'h0, slot_b[PACK*k], slot_b[PACK*k+1],
                          slot_b[PACK*k+2], slot_b[PACK*k+3]});
      if (trl)
         exp_q.push_back({4'h2, 16'(sq), 8'(dr), 7'b0, ovf});
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_chk += 5;
      if (fifo_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_wr got %b want 0", fifo_wr_en);
      end
      if (data_out !== 36'h0) begin
         n_fail++; $display("FAIL rst_dout got %h want 0", data_out);
      end
      if (locked !== 1'b0) begin
         n_fail++; $display("FAIL rst_locked got %b want 0", locked);
      end
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy got %b want 0", busy);
      end
      if (drop_cnt !== 8'h0) begin
         n_fail++; $display("FAIL rst_drop got %h want 0", drop_cnt);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      evt_total = 0;
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL first_lock got %b want 1", locked);
      end
   endtask

   task automatic test_trigger();
      send_slot(1, FW, 2, 20, FW, 0, $urandom_range(0, 3));
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      exp_frame(FW / PACK, 1, 0, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL trig_busy got %b want 0", busy);
      end
      n_chk++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL trig_count got %0d want %0d",
                  got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL trig_w%0d got %h want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      send_slot(1, FW, 1, 20, FW, 0, 2);
      for (int f = 0; f < 3; f++) begin
         send_slot(1, FW, 0, NONE, FW, 0, 0);
         exp_frame(FW / PACK, 1, 0, f, 0);
      end
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (got_q.size() !== 3 * 14) begin
         n_fail++;
         $display("FAIL b2b_count got %0d want %0d",
                  got_q.size(), 3 * 14);
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_w%0d got %h want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_stop();
      send_slot(1, FW, 1, 20, FW, 0, 1);
      send_slot(1, FW, 3, 30, FW, 0, 0);
      exp_frame(FW / PACK, 1, 0, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL stop_count got %0d want %0d",
                  got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL stop_w%0d got %h want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_miss();
      send_slot(0, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL miss1_locked got %b want 1", locked);
      end
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      send_slot(0, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL miss2a_locked got %b want 1", locked);
      end
      send_slot(0, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (locked !== 1'b0) begin
         n_fail++; $display("FAIL miss2b_locked got %b want 0", locked);
      end
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL relock got %b want 1", locked);
      end
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (got_q.size() !== 0) begin
         n_fail++;
         $display("FAIL miss_writes got %0d want 0", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_drop();
      send_slot(1, FW, 1, 20, FW, 0, 0);
      send_slot(1, FW, 0, NONE, 0, 1, 0);
      for (int f = 0; f < 3; f++) begin
         send_slot(1, FW, 0, NONE, FW, 0, 0);
         exp_frame(FW / PACK, 1, 0, f, 1);
      end
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (drop_cnt !== 8'd1) begin
         n_fail++; $display("FAIL drop_cnt got %0d want 1", drop_cnt);
      end
      n_chk++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL drop_count got %0d want %0d",
                  got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL drop_w%0d got %h want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_overflow();
      int ff, nd;
      ff = $urandom_range(12, 28);
      nd = 0;
      while (nd < FW / PACK &&
             !((PACK*nd + PACK - 1) >= ff &&
               (PACK*nd + PACK - 1) < ff + 5))
         nd++;
      send_slot(1, FW, 2, 20, FW, 0, 1);
      send_slot(1, FW, 2, 40, ff, 5, 0);
      exp_frame(nd, 1, 1, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      exp_frame(FW / PACK, 1, 0, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL ovf_count got %0d want %0d",
                  got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ovf_w%0d got %h want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      send_slot(1, FW, 2, 20, FW, 0, $urandom_range(0, 2));
      send_slot(1, 11, 0, NONE, FW, 0, 0);
      exp_frame(10 / PACK, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      n_chk += 5;
      if (fifo_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL mid_wr got %b want 0", fifo_wr_en);
      end
      if (data_out !== 36'h0) begin
         n_fail++; $display("FAIL mid_dout got %h want 0", data_out);
      end
      if (locked !== 1'b0) begin
         n_fail++; $display("FAIL mid_locked got %b want 0", locked);
      end
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_busy got %b want 0", busy);
      end
      if (drop_cnt !== 8'h0) begin
         n_fail++; $display("FAIL mid_drop got %h want 0", drop_cnt);
      end
      #2 rst_n = 1'b1;
      evt_total = 0;
      send_slot(0, FW - 11, 0, NONE, FW, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      send_slot(1, FW, 0, NONE, FW, 0, 0);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++; $display("FAIL mid_relock got %b want 1", locked);
      end
      n_chk++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL mid_count got %0d want %0d",
                  got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_chk++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL mid_w%0d got %h want %h",
                     i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_trigger();
      test_back_to_back();
      test_stop();
      test_miss();
      test_drop();
      test_overflow();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
